// File: rtl/arm_dp_pkg.sv
// Shared definitions for the datapath memory sequencer: access size codes
// and the memory FSM state type.
package arm_dp_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10,
        ST_FAULT  = 2'b11
    } mem_state_t;

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering for one 32-bit memory word: byte enables plus either
// store-data replication (i_store=1) or load-data extraction and extension.
module lane_align #(
    parameter int BIG_ENDIAN = 0
) (
    input  logic        i_store,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_sign,
    input  logic [31:0] i_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_data
);
    import arm_dp_pkg::*;

    logic [1:0]  w_byte_lane;
    logic        w_half_lane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Big-endian mirrors the lane index; the word itself is never byte-swapped.
    assign w_byte_lane = (BIG_ENDIAN != 0) ? (2'd3 - i_off) : i_off;
    assign w_half_lane = (BIG_ENDIAN != 0) ? ~i_off[1] : i_off[1];
    assign w_byte      = i_data[{w_byte_lane, 3'b000} +: 8];
    assign w_half      = i_data[{w_half_lane, 4'b0000} +: 16];

    always_comb begin
        o_be   = 4'b0000;
        o_data = i_data;
        case (i_size)
            SZ_BYTE: begin
                o_be   = 4'b0001 << w_byte_lane;
                o_data = i_store ? {4{i_data[7:0]}}
                                 : {{24{i_sign & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be   = w_half_lane ? 4'b1100 : 4'b0011;
                o_data = i_store ? {2{i_data[15:0]}}
                                 : {{16{i_sign & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_be   = 4'b1111;
                o_data = i_data;
            end
            default: begin
                o_be   = 4'b0000;
                o_data = i_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer: owns MAR/MDR, handshakes req/done with the control
// unit and drives a single-word data memory port with lane steering and timeout.
module mem_access_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 15,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rdy
);
    import arm_dp_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic [ADDR_W-1:0] r_mar;
    logic [31:0]       r_mdr;
    logic [31:0]       r_rdata;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sign;
    logic [1:0]        r_off;
    logic [CNT_W-1:0]  r_cnt;

    logic [3:0]  w_st_be;
    logic [31:0] w_st_data;
    logic [3:0]  w_ld_be;
    logic [31:0] w_ld_data;
    logic        w_misalign;
    logic        w_cnt_last;
    logic        w_accept;

    // Store path works on the live request inputs so MDR is loaded pre-steered.
    lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_store_align (
        .i_store (1'b1),
        .i_size  (size),
        .i_off   (addr[1:0]),
        .i_sign  (sign),
        .i_data  (wdata),
        .o_be    (w_st_be),
        .o_data  (w_st_data)
    );

    lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_load_align (
        .i_store (1'b0),
        .i_size  (r_size),
        .i_off   (r_off),
        .i_sign  (r_sign),
        .i_data  (mem_rdata),
        .o_be    (w_ld_be),
        .o_data  (w_ld_data)
    );

    // The lane decoder yields no enables only for the reserved size code.
    assign w_misalign = (w_st_be == 4'b0000)
                      | ((size == SZ_HALF) & addr[0])
                      | ((size == SZ_WORD) & (addr[1:0] != 2'b00));
    assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_accept   = (r_state == ST_IDLE) & req;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req) w_state_next = w_misalign ? ST_FAULT : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (mem_rdy)         w_state_next = ST_DONE;
                else if (w_cnt_last) w_state_next = ST_FAULT;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            ST_FAULT: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= ST_IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sign  <= 1'b0;
            r_off   <= 2'b00;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_mar  <= {addr[ADDR_W-1:2], 2'b00};
                r_mdr  <= w_st_data;
                r_we   <= we;
                r_size <= size;
                r_sign <= sign;
                r_off  <= addr[1:0];
                r_cnt  <= '0;
            end
            if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (mem_rdy && !r_we) r_rdata <= w_ld_data;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE) | (r_state == ST_FAULT);
    assign fault     = (r_state == ST_FAULT);
    assign mem_en    = (r_state == ST_ACCESS);
    assign mem_rw    = mem_en & r_we;
    assign mem_be    = mem_en ? w_ld_be : 4'b0000;
    assign mem_addr  = r_mar;
    assign mem_wdata = r_mdr;
    assign rdata     = r_rdata;

endmodule
